// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with optional word rotation (loop) mode.
// All outputs come straight from flops loaded with next-cycle values.
module piso_tx #(
    parameter int W         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         ck,
    input  logic         cl,
    input  logic         start,
    input  logic [W-1:0] din,
    input  logic         loop,
    output logic         so,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           so_q, so_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   rot;

    function automatic logic head(input logic [W-1:0] x);
        return LSB_FIRST ? x[0] : x[W-1];
    endfunction

    // Head bit re-enters at the tail, so W rotations restore the word.
    function automatic logic [W-1:0] rotate(input logic [W-1:0] x);
        return LSB_FIRST ? {x[0], x[W-1:1]} : {x[W-2:0], x[W-1]};
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        so_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rot     = rotate(sr_q);
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = din;
                    cnt_d   = '0;
                    so_d    = head(din);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sr_d = rot;
                if (cnt_q == LAST) begin
                    if (loop) begin
                        cnt_d   = '0;
                        so_d    = head(rot);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    so_d    = head(rot);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or negedge cl) begin
        if (!cl) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign so    = so_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter W, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0; 0 = MSB transmitted first, 1 = LSB transmitted first.
REQ-003 ck  input  1  Clock; all state changes on rising edge except reset.
REQ-004 cl  input  1  Reset; asynchronous, active-low.
REQ-005 start  input  1  Request to load din and begin a transmission.
REQ-006 din  input  W  Parallel word; sampled only on the edge where start is accepted.
REQ-007 loop  input  1  Repeat mode; while 1, the held word is retransmitted (rotation) without reload.
REQ-008 so  output  1  Serial data out.
REQ-009 valid  output  1  High when so carries a data bit.
REQ-010 busy  output  1  High from the cycle after acceptance until the end of the last bit.
REQ-011 done  output  1  One-cycle pulse after the last bit of a non-repeated word.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: so=0, valid=0, busy=0, done=0; start=1 sampled -> load din into shift register, bit counter=0, go to SHIFT.
REQ-014 SHIFT: valid=1, busy=1; so = current head bit (MSB or LSB per LSB_FIRST); first bit appears on the edge that accepts start (latency 1 cycle from start to first bit).
REQ-015 Each SHIFT cycle: register rotates by one position (head bit re-enters the tail) using simultaneous update; counter increments.
REQ-016 Counter is ceil(log2(W)) bits; at count W-1 the word is complete.
REQ-017 Word complete and loop=1 -> counter wraps to 0, stay in SHIFT; the rotated register equals the original word, so the same word restarts with no gap.
REQ-018 Word complete and loop=0 -> go to DONE.
REQ-019 DONE: done=1, busy=0, valid=0, so=0 for exactly one cycle; start=1 in DONE is accepted exactly as in IDLE (back-to-back words separated by one idle cycle); otherwise go to IDLE.
REQ-020 start in SHIFT is ignored; din changes in SHIFT have no effect.
REQ-021 loop is sampled only at word completion; toggling mid-word has no effect on the current word.
REQ-022 Exactly W valid cycles per word; no bit is dropped or duplicated.

Reset
REQ-023 cl=0 forces, immediately and independently of ck: state=IDLE, shift register=0, counter=0, so=0, valid=0, busy=0, done=0.
REQ-024 Reset mid-transmission aborts the word with no done pulse; first accepted start after cl returns to 1 behaves as REQ-013.
REQ-025 While cl=0, start is ignored.

Verification
REQ-026 W=8, LSB_FIRST=0, din=8'hA5, start one cycle -> so = 1,0,1,0,0,1,0,1 over 8 cycles with valid=1, busy=1, then done=1 for one cycle, then IDLE.
REQ-027 LSB_FIRST=1, din=8'h01 -> so = 1,0,0,0,0,0,0,0; done after 8 bits.
REQ-028 loop=1, din=8'hC3 -> pattern 1,1,0,0,0,0,1,1 repeats with no gap for 3 words; loop=0 during word 3 -> done after end of word 3 only.
REQ-029 start held high continuously, din=8'hFF then 8'h00 -> words separated by exactly one DONE cycle; din change during SHIFT does not alter the current word.
REQ-030 cl pulsed low at bit 4 of din=8'hF0, asynchronous to ck -> all outputs 0 immediately, no done pulse; next start with din=8'h0F transmits 0,0,0,0,1,1,1,1.
REQ-031 start pulsed during SHIFT -> ignored; valid count per word remains exactly 8.
